// File: rtl/obi_master_pkg.sv
// obi_master_pkg: shared types and default widths for the OBI master.
// Holds the transaction FSM state encoding and the default bus widths.
package obi_master_pkg;

  localparam int OBI_ADDR_WIDTH = 32;
  localparam int OBI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    RSP
  } obi_state_e;

endpackage

// File: rtl/obi_master_be.sv
// obi_master_be: single-outstanding OBI master with byte enables.
// Turns one controller command into one OBI A/R transaction.
//
// Ports:
//   clk_i, reset_i       clock, async active-high reset
//   cmd_*                controller command (valid/ready, we, addr, be, wdata)
//   rsp_*                controller response (valid/ready, rdata, err)
//   obi_req_o/gnt_i      OBI A-channel handshake, addr/we/be/wdata
//   obi_rvalid_i/rready  OBI R-channel handshake, rdata/err
//
// Option: define OBI_MASTER_ALIGN_CHK_EN to reject commands whose byte
// enables touch lanes below the address offset; those go straight to
// a response with rsp_err_o=1 and never reach the bus.
module obi_master_be
  import obi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = OBI_ADDR_WIDTH,
  parameter int DATA_WIDTH = OBI_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  output logic                    obi_rready_o,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  obi_state_e state_q, state_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic misalign;

`ifdef OBI_MASTER_ALIGN_CHK_EN
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 1;

  logic [OFF_W-1:0] off;

  assign off = cmd_addr_i[OFF_W-1:0];

  // A lane below the byte offset cannot be reached within this word.
  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (BE_W > 1 && cmd_be_i[i] && i < int'(off)) begin
        misalign = 1'b1;
      end
    end
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          be_d    = cmd_be_i;
          wdata_d = cmd_we_i ? cmd_wdata_i : '0;
          // A rejected command answers with err and no data.
          rdata_d = '0;
          err_d   = misalign;
          state_d = misalign ? RSP : REQ;
        end
      end
      REQ: begin
        if (obi_gnt_i) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (obi_rvalid_i) begin
          rdata_d = we_q ? '0 : obi_rdata_i;
          err_d   = obi_err_i;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign obi_req_o    = (state_q == REQ);
  assign obi_rready_o = (state_q == WAIT_R);
  assign rsp_valid_o  = (state_q == RSP);

  // Bus and response fields read as zero outside their phase.
  assign obi_addr_o  = obi_req_o ? addr_q : '0;
  assign obi_we_o    = obi_req_o & we_q;
  assign obi_be_o    = obi_req_o ? be_q : '0;
  assign obi_wdata_o = obi_req_o ? wdata_q : '0;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;

endmodule

// File: doc/obi_master_be.md
OBI_MASTER_BE -- requirements
Module: obi_master_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, OBI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8); BE width DATA_WIDTH/8.
REQ-003 SHALL have one clock and an asynchronous active-high reset: clk_i  in  1  clock, rising edge; reset_i  in  1  async active-high reset.
REQ-004 cmd_valid_i  in  1  controller command valid.
REQ-005 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-006 cmd_we_i  in  1  1=write, 0=read.
REQ-007 cmd_addr_i  in  ADDR_WIDTH  byte address.
REQ-008 cmd_be_i  in  DATA_WIDTH/8  byte enables.
REQ-009 cmd_wdata_i  in  DATA_WIDTH  write data.
REQ-010 rsp_valid_o  out  1  response available.
REQ-011 rsp_ready_i  in  1  controller consumes response.
REQ-012 rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes).
REQ-013 rsp_err_o  out  1  error flag of response.
REQ-014 obi_req_o  out  1  OBI A-channel request.
REQ-015 obi_gnt_i  in  1  OBI grant.
REQ-016 obi_addr_o  out  ADDR_WIDTH  OBI address.
REQ-017 obi_we_o  out  1  OBI write enable.
REQ-018 obi_be_o  out  DATA_WIDTH/8  OBI byte enables.
REQ-019 obi_wdata_o  out  DATA_WIDTH  OBI write data.
REQ-020 obi_rvalid_i  in  1  OBI R-channel valid.
REQ-021 obi_rready_o  out  1  OBI R-channel ready.
REQ-022 obi_rdata_i  in  DATA_WIDTH  OBI read data.
REQ-023 obi_err_i  in  1  OBI error.

Function
REQ-024 SHALL implement FSM IDLE -> REQ -> WAIT_R -> RSP -> IDLE; at most one transaction outstanding.
REQ-025 IDLE: cmd_ready_o=1; on cmd_valid_i register we/addr/be/wdata, next state REQ; all other outputs 0.
REQ-026 REQ: obi_req_o=1 with registered addr/we/be/wdata held stable until obi_gnt_i sampled high; then WAIT_R; no req deassertion before grant.
REQ-027 obi_wdata_o SHALL be 0 for reads; obi_be_o SHALL carry cmd_be_i unchanged for both reads and writes.
REQ-028 WAIT_R: obi_rready_o=1; on obi_rvalid_i capture obi_rdata_i (reads only, else 0) and obi_err_i, next state RSP.
REQ-029 obi_rvalid_i outside WAIT_R SHALL be ignored; obi_gnt_i outside REQ SHALL be ignored.
REQ-030 RSP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable until rsp_ready_i high; then IDLE.
REQ-031 Latency with gnt and rvalid immediate: cmd accept edge 0, obi_req_o high cycle 1, rvalid accepted cycle 2, rsp_valid_o high cycle 3; minimum 4 cycles per transaction.
REQ-032 cmd_be_i==0 SHALL still issue a bus transaction (no local shortcut).

Reset
REQ-033 reset_i SHALL asynchronously force IDLE, all outputs 0 except cmd_ready_o=1 after release; all capture registers cleared.
REQ-034 Reset mid-transaction SHALL drop obi_req_o/obi_rready_o immediately and discard any pending response.

Configuration
REQ-035 With OBI_MASTER_ALIGN_CHK_EN defined, a command whose cmd_be_i has set bits outside the lanes reachable from cmd_addr_i[1:0] within the word (for DATA_WIDTH=32: lane index < addr[1:0]) SHALL skip REQ/WAIT_R, go IDLE -> RSP with rsp_err_o=1, rsp_rdata_o=0; without the macro no check is made and every command goes to the bus.

Structure
REQ-036 Package obi_master_pkg SHALL hold the state enum (IDLE, REQ, WAIT_R, RSP) and the default width constants; no sub-module (single flat module).

Verification
REQ-037 Read 0x0000_0004, slave returns 0xDA7A5EAD -> rsp_valid_o with rsp_rdata_o=0xDA7A5EAD, rsp_err_o=0, obi_be_o=4'b1111 during request.
REQ-038 Write 0x1337_C0DE to 0x0000_0008, be 4'b1111, gnt delayed 3 cycles -> obi_req_o held with stable addr/wdata for 4 cycles, rsp_err_o=0.
REQ-039 Read with obi_err_i=1 on rvalid -> rsp_err_o=1; rsp_ready_i held low 5 cycles -> response stable, cmd_ready_o=0 throughout.
REQ-040 reset_i pulsed while in REQ -> obi_req_o=0 same cycle, FSM IDLE, no rsp_valid_o afterwards.
REQ-041 With OBI_MASTER_ALIGN_CHK_EN: addr 0x0000_000F, be 4'b0001 -> no obi_req_o, rsp_err_o=1; addr 0x0000_000F, be 4'b1000 -> normal bus write.
